// File: rtl/shreg_frame_sequencer.sv
// Frame scheduler for the static/dynamic shift-register generator: one static frame,
// then DYNPERSTAT dynamic frames, with a one-deep buffer feeding the active dynamic word.
module shreg_frame_sequencer #(
   parameter int unsigned SIZESRSTAT = 88,
   parameter int unsigned SIZESRDYN  = 16,
   parameter int unsigned GAP        = 2,
   parameter int unsigned DYNPERSTAT = 4,
   parameter int unsigned CNTW       = 7
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 dyn_valid_i,
   input  logic [SIZESRDYN-1:0] dyn_data_i,
   output logic                 dyn_ready_o,
   output logic                 selstat_o,
   output logic                 seldyn_o,
   output logic [SIZESRDYN-1:0] dynreg_o,
   output logic [CNTW-1:0]      bit_cnt_o,
   output logic                 busy_o,
   output logic                 frame_done_o,
   output logic                 underrun_o
);

   localparam int unsigned DCW       = $clog2(DYNPERSTAT + 1);
   localparam int unsigned STAT_LAST = SIZESRSTAT - 1;
   localparam int unsigned DYN_LAST  = SIZESRDYN - 1;
   localparam int unsigned GAP_LAST  = (GAP == 0) ? 0 : GAP - 1;
   localparam int unsigned DPS_LAST  = DYNPERSTAT - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STAT,
      S_GAPW,
      S_DYN
   } state_e;

   state_e                state_q, state_d;
   state_e                target_q, target_d;
   state_e                after_dyn;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic [DCW-1:0]        dyn_cnt_q, dyn_cnt_d;
   logic                  stop_pend_q, stop_pend_d;
   logic                  buf_full_q, buf_full_d;
   logic [SIZESRDYN-1:0]  buf_q, buf_d;
   logic [SIZESRDYN-1:0]  dynreg_q, dynreg_d;
   logic                  enter_dyn;
   logic                  accept;

   logic                  dyn_ready_q;
   logic                  selstat_q;
   logic                  seldyn_q;
   logic [CNTW-1:0]       bit_cnt_q;
   logic                  busy_q;
   logic                  frame_done_q;
   logic                  underrun_q;

   // Schedule next-state: counter, frame target, dynamic-frame count, stop request
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      cnt_d       = cnt_q;
      dyn_cnt_d   = dyn_cnt_q;
      stop_pend_d = stop_pend_q;
      enter_dyn   = 1'b0;
      after_dyn   = S_DYN;

      if (state_q != S_IDLE && stop_i) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d     = S_STAT;
               cnt_d       = '0;
               dyn_cnt_d   = '0;
               stop_pend_d = stop_i;
            end
         end
         S_STAT: begin
            if (cnt_q == CNTW'(STAT_LAST)) begin
               cnt_d = '0;
               if (GAP == 0) begin
                  state_d   = S_DYN;
                  enter_dyn = 1'b1;
               end else begin
                  state_d  = S_GAPW;
                  target_d = S_DYN;
               end
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_GAPW: begin
            if (cnt_q == CNTW'(GAP_LAST)) begin
               cnt_d     = '0;
               state_d   = target_q;
               enter_dyn = (target_q == S_DYN);
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_DYN: begin
            if (cnt_q == CNTW'(DYN_LAST)) begin
               cnt_d = '0;
               if (stop_pend_q) begin
                  state_d     = S_IDLE;
                  stop_pend_d = 1'b0;
                  dyn_cnt_d   = '0;
               end else begin
                  if (dyn_cnt_q == DCW'(DPS_LAST)) begin
                     dyn_cnt_d = '0;
                     after_dyn = S_STAT;
                  end else begin
                     dyn_cnt_d = dyn_cnt_q + DCW'(1);
                     after_dyn = S_DYN;
                  end
                  if (GAP == 0) begin
                     state_d   = after_dyn;
                     enter_dyn = (after_dyn == S_DYN);
                  end else begin
                     state_d  = S_GAPW;
                     target_d = after_dyn;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Word buffer: drained into the active register at DYN entry, refilled on handshake
   assign accept = dyn_valid_i & dyn_ready_q;

   always_comb begin
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      dynreg_d   = dynreg_q;
      if (enter_dyn && buf_full_q) begin
         dynreg_d   = buf_q;
         buf_full_d = 1'b0;
      end
      if (accept) begin
         buf_d      = dyn_data_i;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         target_q     <= S_IDLE;
         cnt_q        <= '0;
         dyn_cnt_q    <= '0;
         stop_pend_q  <= 1'b0;
         buf_full_q   <= 1'b0;
         buf_q        <= '0;
         dynreg_q     <= '0;
         dyn_ready_q  <= 1'b0;
         selstat_q    <= 1'b0;
         seldyn_q     <= 1'b0;
         bit_cnt_q    <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         cnt_q        <= cnt_d;
         dyn_cnt_q    <= dyn_cnt_d;
         stop_pend_q  <= stop_pend_d;
         buf_full_q   <= buf_full_d;
         buf_q        <= buf_d;
         dynreg_q     <= dynreg_d;
         dyn_ready_q  <= ~buf_full_d;
         selstat_q    <= (state_d == S_STAT);
         seldyn_q     <= (state_d == S_DYN);
         bit_cnt_q    <= (state_d == S_STAT || state_d == S_DYN) ? cnt_d : '0;
         busy_q       <= (state_d != S_IDLE);
         frame_done_q <= (state_d == S_DYN) && (cnt_d == CNTW'(DYN_LAST));
         underrun_q   <= enter_dyn & ~buf_full_q;
      end
   end

   assign dyn_ready_o  = dyn_ready_q;
   assign selstat_o    = selstat_q;
   assign seldyn_o     = seldyn_q;
   assign dynreg_o     = dynreg_q;
   assign bit_cnt_o    = bit_cnt_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_shreg_frame_sequencer.sv
// Directed bench for shreg_frame_sequencer: free-run schedule, word buffering/underrun,
// STOP handling (incl. START+STOP together) and mid-frame reset.
module tb_shreg_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        dyn_valid;
   logic [15:0] dyn_data;
   logic        dyn_ready;
   logic        selstat;
   logic        seldyn;
   logic [15:0] dynreg;
   logic [6:0]  bit_cnt;
   logic        busy;
   logic        frame_done;
   logic        underrun;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;

   shreg_frame_sequencer dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .stop_i       (stop),
      .dyn_valid_i  (dyn_valid),
      .dyn_data_i   (dyn_data),
      .dyn_ready_o  (dyn_ready),
      .selstat_o    (selstat),
      .seldyn_o     (seldyn),
      .dynreg_o     (dynreg),
      .bit_cnt_o    (bit_cnt),
      .busy_o       (busy),
      .frame_done_o (frame_done),
      .underrun_o   (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      dyn_valid = 1'b0;
      dyn_data  = '0;
      repeat (3) adv();
      chk("rst_selstat", 32'(selstat), 32'd0);
      chk("rst_seldyn", 32'(seldyn), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(dyn_ready), 32'd0);
      chk("rst_dynreg", 32'(dynreg), 32'd0);
      chk("rst_bitcnt", 32'(bit_cnt), 32'd0);
      rst_n = 1'b1;
      adv();
      chk("idle_ready", 32'(dyn_ready), 32'd1);
   endtask

   // Starts in cycle 0 (optionally with STOP); leaves the bench sampling cycle 1
   task automatic kick(input logic with_stop);
      cyc   = 0;
      start = 1'b1;
      stop  = with_stop;
      adv();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   // Free run with a word at cycle 10 (frame 1) and 115 (frame 3); frames 2 and 4 underrun
   task automatic run_free();
      logic        e_st, e_dy, e_fd, e_ur, e_rdy;
      logic [31:0] e_bc;
      logic [15:0] e_reg;
      int          ph;
      do_reset();
      kick(1'b0);
      for (int c = 1; c <= 170; c++) begin
         e_st = 1'b0;
         e_dy = 1'b0;
         e_bc = 32'd0;
         if (c <= 88) begin
            e_st = 1'b1;
            e_bc = 32'(c - 1);
         end else if (c >= 163) begin
            e_st = 1'b1;
            e_bc = 32'(c - 163);
         end else if (c >= 91) begin
            ph = (c - 91) % 18;
            if (ph < 16) begin
               e_dy = 1'b1;
               e_bc = 32'(ph);
            end
         end
         e_fd  = e_dy && (e_bc == 32'd15);
         e_ur  = (c == 109) || (c == 145);
         e_reg = (c < 91) ? 16'h0000 : (c < 127) ? 16'h1234 : 16'hBEEF;
         e_rdy = (c <= 10) || (c >= 91 && c <= 115) || (c >= 127);
         chk("free_selstat", 32'(selstat), 32'(e_st));
         chk("free_seldyn", 32'(seldyn), 32'(e_dy));
         chk("free_bitcnt", 32'(bit_cnt), e_bc);
         chk("free_fdone", 32'(frame_done), 32'(e_fd));
         chk("free_underrun", 32'(underrun), 32'(e_ur));
         chk("free_dynreg", 32'(dynreg), 32'(e_reg));
         chk("free_ready", 32'(dyn_ready), 32'(e_rdy));
         chk("free_busy", 32'(busy), 32'd1);
         dyn_valid = (c == 10) || (c == 115);
         dyn_data  = (c == 10) ? 16'h1234 : (c == 115) ? 16'hBEEF : 16'h0000;
         adv();
      end
      dyn_valid = 1'b0;
   endtask

   // STOP at cycle stop_c (0 = together with START): one STAT + one DYN frame, then idle
   task automatic run_stop(input int stop_c);
      logic e_st, e_dy, e_busy;
      do_reset();
      kick(stop_c == 0);
      for (int c = 1; c <= 130; c++) begin
         e_st   = (c <= 88);
         e_dy   = (c >= 91) && (c <= 106);
         e_busy = (c <= 106);
         chk("stop_selstat", 32'(selstat), 32'(e_st));
         chk("stop_seldyn", 32'(seldyn), 32'(e_dy));
         chk("stop_busy", 32'(busy), 32'(e_busy));
         chk("stop_fdone", 32'(frame_done), 32'(c == 106));
         chk("stop_underrun", 32'(underrun), 32'(c == 91));
         stop = (c == stop_c);
         adv();
      end
      stop = 1'b0;
   endtask

   // Reset in the middle of the first DYN frame; no restart without START
   task automatic run_midreset();
      do_reset();
      kick(1'b0);
      for (int c = 1; c < 100; c++) begin
         dyn_valid = (c == 5);
         dyn_data  = (c == 5) ? 16'hA5A5 : 16'h0000;
         adv();
      end
      dyn_valid = 1'b0;
      chk("mr_seldyn_pre", 32'(seldyn), 32'd1);
      chk("mr_dynreg_pre", 32'(dynreg), 32'h0000A5A5);
      chk("mr_bitcnt_pre", 32'(bit_cnt), 32'd9);
      rst_n = 1'b0;
      adv();
      chk("mr_seldyn", 32'(seldyn), 32'd0);
      chk("mr_selstat", 32'(selstat), 32'd0);
      chk("mr_dynreg", 32'(dynreg), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_ready", 32'(dyn_ready), 32'd0);
      chk("mr_bitcnt", 32'(bit_cnt), 32'd0);
      rst_n = 1'b1;
      stop  = 1'b1;
      repeat (5) adv();
      stop = 1'b0;
      chk("mr_idle_busy", 32'(busy), 32'd0);
      chk("mr_idle_selstat", 32'(selstat), 32'd0);
      chk("mr_idle_ready", 32'(dyn_ready), 32'd1);
   endtask

   initial begin
      run_free();
      run_stop(50);
      run_stop(0);
      run_midreset();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
